// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - size encodings, FSM states and alignment check for mem_access_unit
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

  // Reserved size 11 is reported the same way as a misaligned access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) ||
           ((size == SZ_WORD) && (lo != 2'b00)) ||
           (size == 2'b11);
  endfunction

endpackage

// File: rtl/mau_lane.sv
// rtl/mau_lane.sv - little-endian lane extract/extend for loads and read-modify-write merge for stores
module mau_lane
  import mau_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  offset,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);

  logic [7:0]  lb;
  logic [15:0] lh;

  assign lb = rword[{offset, 3'b000} +: 8];
  assign lh = rword[{offset[1], 4'b0000} +: 16];

  always_comb begin
    ldata = rword;
    mdata = wdata;
    case (size)
      SZ_BYTE: begin
        ldata = {{24{sign & lb[7]}}, lb};
        mdata = rword;
        mdata[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ldata = {{16{sign & lh[15]}}, lh};
        mdata = rword;
        mdata[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit between core and word-wide data memory
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  input  logic [31:0]       dm_dout
);

  state_t            state, state_nxt;
  logic              we_q, sign_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, data_q;
  logic [31:0]       ldata, mdata;
  logic              accept, req_mis;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign req_mis   = misaligned(req_size, req_addr[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_mis)                          state_nxt = RESP;
          else if (req_we && req_size == SZ_WORD) state_nxt = WRITE;
          else                                  state_nxt = READ;
        end
      end
      READ:    state_nxt = we_q ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // data_q holds the extended load result or the merged store word after READ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      sign_q  <= req_sign;
      err_q   <= req_mis;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      data_q  <= '0;
    end else if (state == READ) begin
      data_q  <= we_q ? mdata : ldata;
    end
  end

  mau_lane u_lane (
    .size   (size_q),
    .sign   (sign_q),
    .offset (addr_q[1:0]),
    .rword  (dm_dout),
    .wdata  (wdata_q),
    .ldata  (ldata),
    .mdata  (mdata)
  );

  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ? data_q : 32'h0;
  assign dm_we      = (state == WRITE);
  assign dm_addr    = (state == READ || state == WRITE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign dm_din     = dm_we ? ((size_q == SZ_WORD) ? wdata_q : data_q) : 32'h0;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning byte-address width toward data memory.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  core presents an access.
REQ-005 SHALL have port req_ready  output  1  unit accepts an access this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port req_sign  input  1  loads: 1 sign-extend, 0 zero-extend.
REQ-009 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  load result, extended.
REQ-013 SHALL have port resp_err  output  1  misaligned or reserved-size access; valid with resp_valid.
REQ-014 SHALL have port dm_addr  output  ADDR_W  word-aligned address to data memory, low 2 bits always 0.
REQ-015 SHALL have port dm_din  output  32  write word to data memory.
REQ-016 SHALL have port dm_we  output  1  data-memory write enable, sampled by memory on rising clk.
REQ-017 SHALL have port dm_dout  input  32  combinational read word from data memory at dm_addr.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 Accept = req_valid & req_ready; on accept, SHALL register we, size, sign, addr, wdata.
REQ-020 Misaligned = (size 01 & addr[0]) | (size 10 & addr[1:0]!=0) | size 11; on accept: IDLE->RESP, resp_err=1, no memory write.
REQ-021 Load: IDLE->READ->RESP; READ captures dm_dout; resp_valid 2 cycles after accept.
REQ-022 Word store: IDLE->WRITE->RESP; WRITE drives dm_we=1, dm_din=wdata; resp_valid 2 cycles after accept.
REQ-023 Sub-word store: IDLE->READ->WRITE->RESP; READ captures old word, WRITE writes merged word, untouched lanes preserved; resp_valid 3 cycles after accept.
REQ-024 RESP SHALL last exactly one cycle and return to IDLE; next access may be accepted the cycle after RESP.
REQ-025 Byte lanes little-endian: addr[1:0]=0 selects bits 7:0, 3 selects 31:24; halfword addr[1]=0 selects 15:0, 1 selects 31:16.
REQ-026 Byte store SHALL use req_wdata[7:0]; halfword store req_wdata[15:0]; upper bits ignored.
REQ-027 resp_rdata SHALL be 0 for stores and errors; dm_we SHALL be 1 only in WRITE.
REQ-028 dm_addr SHALL equal {addr[ADDR_W-1:2],2'b00} of the registered request in READ/WRITE, 0 otherwise.
REQ-029 req_valid while not ready SHALL be ignored; requester holds request until accepted.

Reset
REQ-030 On rst: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, dm_we=0, dm_addr=0, dm_din=0, all captured registers 0.
REQ-031 rst asserted mid-operation (including WRITE) SHALL abort immediately: dm_we falls asynchronously, no response issued.

Structure
REQ-032 Shared package mau_pkg SHALL hold size encodings SZ_BYTE/SZ_HALF/SZ_WORD and the FSM state enum.
REQ-033 Lane extract/extend and store merge SHALL be one combinational sub-module mau_lane.

Verification
REQ-034 Mem[0x10]=0x8899AABB; load byte signed addr 0x13 -> resp_rdata 0xFFFFFF88, resp_valid 2 cycles after accept.
REQ-035 Same word; load half unsigned addr 0x12 -> 0x00008899; load half signed addr 0x10 -> 0xFFFFAABB.
REQ-036 Store byte 0x5A to 0x11 over 0x8899AABB -> mem 0x88995ABB, dm_we exactly 1 cycle, resp 3 cycles after accept.
REQ-037 Store word 0x12345678 to 0x20 -> mem 0x12345678, resp 2 cycles; then load word -> 0x12345678.
REQ-038 Store half to 0x21 -> resp_err=1 next cycle, dm_we never 1, memory unchanged.
REQ-039 Assert rst during WRITE of sub-word store -> dm_we 0 immediately, state IDLE, no resp_valid, req_ready=1.
